// File: rtl/fifo_pkg.sv
// Shared constants, count-width helper and packed status word for the
// synchronous FIFO and its monitors.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Push/pop handshake and status bundle between a FIFO and its agents.
interface sync_fifo_if import fifo_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int CW = count_width(DEPTH);

  logic             push;
  logic [WIDTH-1:0] wr_data;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, wr_data, pop, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, wr_data, pop, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one write port, one registered read port.
module fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage array; contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= {WIDTH{1'b0}};
    end else if (i_re) begin
      r_rd_data <= r_mem[i_raddr];
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, registered status and sticky
// error flags around a fifo_mem storage array.
module sync_fifo import fifo_pkg::*; #(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic        clk,
  input logic        rst_n,
  sync_fifo_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1,
                                          almost_full: 1'b0, almost_empty: 1'b1,
                                          overflow: 1'b0, underflow: 1'b0};

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("sync_fifo: need 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_rd_valid;
  fifo_status_t  r_status;
  fifo_status_t  w_status_nxt;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_push_rej;
  logic          w_pop_rej;

  // Acceptance uses only the registered (pre-edge) full/empty.
  assign w_push_ok  = bus.push & ~r_status.full;
  assign w_pop_ok   = bus.pop  & ~r_status.empty;
  assign w_push_rej = bus.push &  r_status.full;
  assign w_pop_rej  = bus.pop  &  r_status.empty;

  // Next occupancy and the status word derived from it.
  always_comb begin
    w_count_nxt  = r_count;
    w_status_nxt = r_status;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_status_nxt.full         = (w_count_nxt == CW'(DEPTH));
    w_status_nxt.empty        = (w_count_nxt == CW'(0));
    w_status_nxt.almost_full  = (w_count_nxt >= CW'(AF_LEVEL));
    w_status_nxt.almost_empty = (w_count_nxt <= CW'(AE_LEVEL));
    // A fresh error in the same cycle as clr_err keeps the flag set.
    if (w_push_rej) begin
      w_status_nxt.overflow = 1'b1;
    end else if (bus.clr_err) begin
      w_status_nxt.overflow = 1'b0;
    end else begin
      w_status_nxt.overflow = r_status.overflow;
    end
    if (w_pop_rej) begin
      w_status_nxt.underflow = 1'b1;
    end else if (bus.clr_err) begin
      w_status_nxt.underflow = 1'b0;
    end else begin
      w_status_nxt.underflow = r_status.underflow;
    end
  end

  // Pointer, occupancy, status and read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= AW'(0);
      r_rd_ptr   <= AW'(0);
      r_count    <= CW'(0);
      r_status   <= STATUS_RST;
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_status   <= w_status_nxt;
      r_rd_valid <= w_pop_ok;
      r_wr_ptr   <= w_push_ok ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
      r_rd_ptr   <= w_pop_ok  ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    end
  end

  fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_push_ok),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (bus.wr_data),
    .i_re      (w_pop_ok),
    .i_raddr   (r_rd_ptr),
    .o_rd_data (bus.rd_data)
  );

  assign bus.rd_valid     = r_rd_valid;
  assign bus.count        = r_count;
  assign bus.full         = r_status.full;
  assign bus.empty        = r_status.empty;
  assign bus.almost_full  = r_status.almost_full;
  assign bus.almost_empty = r_status.almost_empty;
  assign bus.overflow     = r_status.overflow;
  assign bus.underflow    = r_status.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: queue-based reference model compared every
// cycle, plus hand-computed literal checks.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(DEPTH - 2), .AE_LEVEL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_rd_data;
  logic             m_rd_valid;
  logic             m_ovf;
  logic             m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
  endtask

  // Applies the rules of one clock edge to the queue model.
  task automatic model_update();
    bit was_full;
    bit was_empty;
    was_full   = (m_q.size() == DEPTH);
    was_empty  = (m_q.size() == 0);
    m_rd_valid = bus.pop && !was_empty;
    if (m_rd_valid) m_rd_data = m_q.pop_front();
    if (bus.push && !was_full) m_q.push_back(bus.wr_data);
    if (bus.push && was_full) m_ovf = 1'b1;
    else if (bus.clr_err) m_ovf = 1'b0;
    if (bus.pop && was_empty) m_unf = 1'b1;
    else if (bus.clr_err) m_unf = 1'b0;
  endtask

  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic q, input logic c);
    bus.push    = p;
    bus.wr_data = d;
    bus.pop     = q;
    bus.clr_err = c;
    @(posedge clk);
    model_update();
    #2;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
      chk("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
      chk("count", 32'(bus.count), 32'(m_q.size()));
      chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(m_q.size() >= DEPTH - 2));
      chk("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= 2));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end

  initial begin
    bus.push    = 1'b0;
    bus.wr_data = '0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_count", 32'(bus.count), 32'd0);
      chk("idle_empty", 32'(bus.empty), 32'd1);
    end

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 5) chk("af_at5", 32'(bus.almost_full), 32'd0);
      if (i == 6) chk("af_at6", 32'(bus.almost_full), 32'd1);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_valid", 32'(bus.rd_valid), 32'd1);
      chk("drain_data", 32'(bus.rd_data), 32'(i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("ovf_rd_data", 32'(bus.rd_data), 32'h01);
    chk("ovf_count", 32'(bus.count), 32'd7);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ovf_drain", 32'(bus.rd_data), 32'(i));
    end
    chk("ovf_empty", 32'(bus.empty), 32'd1);

    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_valid", 32'(bus.rd_valid), 32'd0);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    chk("unf_hold", 32'(bus.rd_data), 32'h08);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_unf", 32'(bus.underflow), 32'd0);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("clr_vs_unf", 32'(bus.underflow), 32'd1);

    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h0D + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
      chk("wrap_count", 32'(bus.count), 32'd3);
      chk("wrap_data", 32'(bus.rd_data), 32'(8'h0D + i));
    end

    step(1'b1, 8'h30, 1'b0, 1'b0);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    chk("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_data", 32'(bus.rd_data), 32'h55);
    chk("post_rst_valid", 32'(bus.rd_valid), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
